// File: rtl/joy_pkg.sv
// Shared mode codes, direction bit indices and priority helper for the joystick direction filter.
package joy_pkg;

  localparam logic [2:0] MODE_PASS       = 3'd0;
  localparam logic [2:0] MODE_EIGHT      = 3'd1;
  localparam logic [2:0] MODE_FOUR_NEW   = 3'd2;
  localparam logic [2:0] MODE_FOUR_FIRST = 3'd3;
  localparam logic [2:0] MODE_TWO_H      = 3'd4;
  localparam logic [2:0] MODE_TWO_V      = 3'd5;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  // Highest-priority set bit as a one-hot: up > down > left > right.
  function automatic logic [3:0] prio_onehot(input logic [3:0] v);
    logic [3:0] r;
    r = '0;
    if (v[DIR_UP])         r[DIR_UP]    = 1'b1;
    else if (v[DIR_DOWN])  r[DIR_DOWN]  = 1'b1;
    else if (v[DIR_LEFT])  r[DIR_LEFT]  = 1'b1;
    else if (v[DIR_RIGHT]) r[DIR_RIGHT] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/joy_dir_chan.sv
// One player channel: debounce, rise detect, one-hot selection and mode restriction.
// dir_out lags the accepted (debounced) change by one clk; no backpressure.
module joy_dir_chan #(
  parameter int DEBOUNCE = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic [2:0] mode,
  input  logic       mode_chg,
  input  logic [3:0] raw,
  output logic [3:0] dir_out,
  output logic       new_press
);
  import joy_pkg::*;

  localparam int CW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'((DEBOUNCE > 0) ? DEBOUNCE - 1 : 0);

  logic [3:0]    stable;
  logic [3:0]    stable_q;
  logic [3:0]    sel;
  logic [CW-1:0] cnt [4];

  logic [3:0] rise;
  logic [3:0] elig;
  logic [3:0] held;
  logic [3:0] rise_e;
  logic [3:0] sel_n;
  logic [3:0] out_n;
  logic       four_way;
  logic       first_wins;

  // The ce tick that brings a counter to DEBOUNCE also accepts the new level.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= '0;
      for (int b = 0; b < 4; b++) cnt[b] <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (raw[b] == stable[b]) begin
          cnt[b] <= '0;
        end else if (DEBOUNCE == 0 || (ce && cnt[b] == DB_LAST)) begin
          stable[b] <= raw[b];
          cnt[b]    <= '0;
        end else if (ce) begin
          cnt[b] <= cnt[b] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    rise       = stable & ~stable_q;
    four_way   = 1'b1;
    first_wins = 1'b0;
    elig       = 4'b1111;
    case (mode)
      MODE_FOUR_NEW:   first_wins = 1'b0;
      MODE_FOUR_FIRST: first_wins = 1'b1;
      MODE_TWO_H:      elig = 4'b0011;
      MODE_TWO_V:      elig = 4'b1100;
      default:         four_way = 1'b0;
    endcase
    held   = stable & elig;
    rise_e = rise & elig;

    // Keep a still-held selection unless a newer rise takes over; otherwise fall back to what is held.
    sel_n = '0;
    if (four_way && !mode_chg) begin
      if ((|(sel & held)) && (first_wins || !(|rise_e))) sel_n = sel;
      else if (|rise_e)                                  sel_n = prio_onehot(rise_e);
      else                                               sel_n = prio_onehot(held);
    end

    out_n = stable;
    if (four_way) begin
      out_n = stable & sel_n;
    end else if (mode == MODE_EIGHT) begin
      if (stable[DIR_UP] && stable[DIR_DOWN]) begin
        out_n[DIR_UP]   = 1'b0;
        out_n[DIR_DOWN] = 1'b0;
      end
      if (stable[DIR_LEFT] && stable[DIR_RIGHT]) begin
        out_n[DIR_LEFT]  = 1'b0;
        out_n[DIR_RIGHT] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q  <= '0;
      sel       <= '0;
      dir_out   <= '0;
      new_press <= 1'b0;
    end else begin
      stable_q  <= stable;
      sel       <= sel_n;
      dir_out   <= out_n;
      new_press <= |rise;
    end
  end

endmodule

// File: rtl/joy_dir_filter.sv
// Multi-channel joystick direction conditioner with runtime restriction mode.
// dir_out follows dir_in 2 clk later (plus debounce time); no backpressure.
module joy_dir_filter #(
  parameter int NCH      = 2,
  parameter int DEBOUNCE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic [2:0]       mode,
  input  logic [4*NCH-1:0] dir_in,
  output logic [4*NCH-1:0] dir_out,
  output logic [NCH-1:0]   new_press
);
  import joy_pkg::*;

  logic [2:0] mode_q;
  logic       mode_chg;

  always_ff @(posedge clk) begin
    if (reset) mode_q <= MODE_PASS;
    else       mode_q <= mode;
  end

  // Channels act on the registered mode; a pending change clears their selection.
  assign mode_chg = (mode != mode_q);

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    joy_dir_chan #(
      .DEBOUNCE (DEBOUNCE)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .ce        (ce),
      .mode      (mode_q),
      .mode_chg  (mode_chg),
      .raw       (dir_in[4*c +: 4]),
      .dir_out   (dir_out[4*c +: 4]),
      .new_press (new_press[c])
    );
  end

endmodule
